// File: rtl/serial_feeder.sv
// ---------------------------------------------------------------------------
// serial_feeder
//
// Purpose:
//   Upstream stage of the bit-serial sequence detector. It takes parallel
//   words over a valid/ready handshake and emits them one bit per clock on X.
//   The detector samples X on every Clk edge. Between words X idles at 0.
//   By default bits leave MSB first. Defining SERIAL_FEEDER_LSB_FIRST_EN
//   emits LSB first. Timing, Word_Done and the handshake are the same in
//   both orders.
//
// Parameters:
//   WIDTH  bits per input word (2..32)
//   GAP    idle cycles after each word before the next can be accepted (0..15)
//
// Ports:
//   Clk        in   rising-edge clock
//   Clr        in   synchronous active-high reset; wins over accept and shift
//   In_Data    in   parallel word; sampled only on the accept edge
//   In_Valid   in   In_Data is valid
//   In_Ready   out  word can be accepted this cycle (combinational)
//   X          out  serial bit to the detector (register bit)
//   X_Valid    out  X carries a data bit this cycle (registered)
//   Word_Done  out  last bit of a word is on X this cycle (registered)
//   Busy       out  FSM is not idle
// ---------------------------------------------------------------------------
module serial_feeder #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic             X,
    output logic             X_Valid,
    output logic             Word_Done,
    output logic             Busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gcnt;
    logic             r_xv;
    logic             r_wd;

    logic             w_last;
    logic             w_accept;

    // The bit on X always sits at the output end of the shift register.
    // Zeros are shifted in behind it, and the register is cleared whenever
    // the FSM leaves SHIFT. That keeps X at 0 outside a word without any
    // output gating.
    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] s);
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
        return {1'b0, s[WIDTH-1:1]};
`else
        return {s[WIDTH-2:0], 1'b0};
`endif
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] s);
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
        return s[0];
`else
        return s[WIDTH-1];
`endif
    endfunction

    assign w_last = (r_state == S_SHIFT) && (r_cnt == '0);

    // Ready is high in IDLE. With no gap it is also high on the final bit,
    // so the next word can follow the current one without a bubble.
    always_comb begin
        In_Ready = 1'b0;
        if (r_state == S_IDLE) begin
            In_Ready = 1'b1;
        end else if (w_last && (GAP == 0)) begin
            In_Ready = 1'b1;
        end
    end

    assign w_accept = In_Valid && In_Ready;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_xv    <= 1'b0;
            r_wd    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= In_Data;
                        r_cnt   <= CNT_LOAD;
                        r_xv    <= 1'b1;
                        r_wd    <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_shift <= shift_next(r_shift);
                        r_cnt   <= r_cnt - 1'b1;
                        // Flag the cycle in which the count reaches zero.
                        r_wd    <= (r_cnt == CNT_W'(1));
                    end else if (GAP > 0) begin
                        r_state <= S_GAP;
                        r_gcnt  <= GAP_LOAD;
                        r_shift <= '0;
                        r_xv    <= 1'b0;
                        r_wd    <= 1'b0;
                    end else if (w_accept) begin
                        // Chained word: the new first bit directly follows
                        // the old last bit.
                        r_shift <= In_Data;
                        r_cnt   <= CNT_LOAD;
                        r_xv    <= 1'b1;
                        r_wd    <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_shift <= '0;
                        r_xv    <= 1'b0;
                        r_wd    <= 1'b0;
                    end
                end

                S_GAP: begin
                    // Entered with GAP-1 loaded, so the FSM spends exactly
                    // GAP cycles here.
                    if (r_gcnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt - 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_shift <= '0;
                    r_xv    <= 1'b0;
                    r_wd    <= 1'b0;
                end
            endcase
        end
    end

    assign X         = out_bit(r_shift);
    assign X_Valid   = r_xv;
    assign Word_Done = r_wd;
    assign Busy      = (r_state != S_IDLE);

endmodule

// File: doc/serial_feeder.md
Name: serial_feeder

Overview:
Upstream stage of the bit-serial sequence detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on X, which the detector samples every Clk edge. X_Valid and Word_Done are provided for monitors and counters. The block idles at X=0 between words.

Parameters:
WIDTH, 8, bits per input word (legal range 2..32)
GAP, 0, idle cycles inserted after each word before the next word can be accepted (legal range 0..15)

Ports:
Clk  input  1  clock, rising edge
Clr  input  1  synchronous, active-high reset
In_Data  input  WIDTH  parallel word to serialise
In_Valid  input  1  In_Data is valid
In_Ready  output  1  block can accept a word this cycle
X  output  1  serial bit to detector, registered
X_Valid  output  1  X carries a data bit this cycle, registered
Word_Done  output  1  high during the cycle the last bit of a word is on X, registered
Busy  output  1  state != IDLE

Behaviour:
- Reset: Clr is sampled on the rising edge of Clk only.
- Reset values: state=IDLE, shift reg=0, bit count=0, gap count=0, X=0, X_Valid=0, Word_Done=0, Busy=0.
- States: IDLE, SHIFT, GAP.
- Accept: a word is accepted when In_Valid && In_Ready at a Clk edge. In_Ready is combinational:
  - 1 in IDLE;
  - 1 in SHIFT on the final bit cycle only when GAP==0;
  - 0 otherwise.
- Latency: word accepted at edge k -> bit WIDTH-1 (MSB) is on X with X_Valid=1 in the cycle after edge k. Remaining bits follow, MSB to LSB, one per cycle, for WIDTH consecutive cycles.
- IDLE: X=0, X_Valid=0. On accept: load the shift register, bit count=WIDTH-1, go to SHIFT.
- SHIFT: X = current bit, X_Valid=1. Each edge: shift, decrement bit count.
- Last bit (bit count==0): Word_Done=1 for exactly that cycle. At the next edge:
  - GAP>0 -> go to GAP with gap count=GAP-1.
  - GAP==0 and accept -> reload and stay in SHIFT. No bubble: the new MSB follows the old LSB directly.
  - GAP==0 and no accept -> go to IDLE.
- GAP: X=0, X_Valid=0, In_Ready=0. Stay for exactly GAP cycles, then go to IDLE.
- In_Data is ignored except at the accept edge. Changes while shifting have no effect.
- In_Valid deasserted with no accept -> no state change.
- Clr mid-word or mid-gap: the in-flight word is discarded. All outputs return to reset values in the cycle after the Clr edge. An In_Valid present at the same edge as Clr is not accepted.
- Clr has priority over the accept and the shift at the same edge.

Optional Feature:
- Macro: SERIAL_FEEDER_LSB_FIRST_EN.
- Defined: bits are emitted LSB first (bit 0 first, bit WIDTH-1 last). All timing, Word_Done and handshake rules are unchanged.
- Undefined: bits are emitted MSB first as specified above.

Test Plan:
1. WIDTH=8, GAP=0: Clr for 2 cycles, then 8'hA5 accepted at edge 3 -> X = 1,0,1,0,0,1,0,1 with X_Valid=1 in cycles 4..11; Word_Done=1 in cycle 11 only; X=0 and In_Ready=1 from cycle 12. Chained detector pulses Z one cycle after each 101 completes.
2. Back-to-back, GAP=0: 8'hA5 then 8'h5A with In_Valid held high -> 16 contiguous X_Valid cycles, X = 10100101 01011010; In_Ready=1 in cycle 0 and in cycle 8 of the first word only.
3. GAP=2: two words 8'hFF, 8'h01 -> after the first Word_Done, 2 cycles of X=0/X_Valid=0/In_Ready=0, then IDLE; second word starts exactly 1 cycle after the accept edge.
4. Mid-word reset: accept 8'hC3, assert Clr after the 3rd bit -> next cycle X=0, X_Valid=0, Word_Done=0, Busy=0, In_Ready=1; the rest of 8'hC3 never appears.
5. Idle hold: In_Valid=0 for 20 cycles after reset -> X=0, X_Valid=0, Busy=0 throughout; In_Data toggling has no effect.
6. With SERIAL_FEEDER_LSB_FIRST_EN, word 8'h0B -> X = 1,1,0,1,0,0,0,0; Word_Done on the 8th bit.
